// File: rtl/lab06_arb_pkg.sv
// Shared types and widths for the lab06 datapath arbiter.
package lab06_arb_pkg;

  localparam int NUM_W  = 4;
  localparam int MODE_W = 2;
  localparam int RES_W  = 7;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester above last_grant, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         winner,
  output logic                       found
);

  int cand;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(last_grant) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req[cand]) begin
        winner[cand] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lab06_arbiter.sv
// Shares one lab06 datapath between NUM_REQ requesters: round-robin grant,
// local batch buffer, contiguous burst into the datapath, result routed back.
module lab06_arbiter
  import lab06_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int BATCH_LEN = 4,
  parameter int TIMEOUT   = 63
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [MODE_W*NUM_REQ-1:0]   req_mode,
  input  logic [NUM_REQ-1:0]          num_valid,
  input  logic [NUM_W*NUM_REQ-1:0]    num_data,
  output logic [NUM_REQ-1:0]          num_ready,
  output logic [NUM_REQ-1:0]          grant,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic signed [RES_W-1:0]     rsp_result,
  output logic                        rsp_timeout,
  output logic                        dp_in_valid,
  output logic [NUM_W-1:0]            dp_in_number,
  output logic [MODE_W-1:0]           dp_mode,
  input  logic                        dp_out_valid,
  input  logic signed [RES_W-1:0]     dp_out_result,
  output logic                        busy
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int CNT_W  = $clog2(BATCH_LEN + 1);
  localparam int BUF_AW = (BATCH_LEN > 1) ? $clog2(BATCH_LEN) : 1;
  localparam int TMR_W  = $clog2(TIMEOUT + 1);

  state_t                   state, state_next;
  logic [MODE_W-1:0]        mode_reg;
  logic [NUM_W-1:0]         buf_mem [BATCH_LEN];
  logic [CNT_W-1:0]         cnt, idx;
  logic [TMR_W-1:0]         timer;
  logic signed [RES_W-1:0]  res_reg;
  logic                     to_flag;
  logic [IDX_W-1:0]         last_grant;

  logic [NUM_REQ-1:0]       winner;
  logic                     found;
  logic [NUM_W-1:0]         sel_num;
  logic [MODE_W-1:0]        win_mode;
  logic [IDX_W-1:0]         g_idx;
  logic                     g_req, accept, load_last, issue_last, timer_hit;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .winner     (winner),
    .found      (found)
  );

  // Steer the owner's number lane and the winner's mode without index arithmetic.
  always_comb begin
    sel_num  = '0;
    win_mode = '0;
    g_idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_num = num_data[i*NUM_W +: NUM_W];
        g_idx   = IDX_W'(i);
      end
      if (winner[i]) win_mode = req_mode[i*MODE_W +: MODE_W];
    end
  end

  assign g_req      = |(req_valid & grant);
  assign accept     = (state == LOAD) && g_req && |(num_valid & grant);
  assign load_last  = accept && (cnt == CNT_W'(BATCH_LEN - 1));
  assign issue_last = (idx == CNT_W'(BATCH_LEN - 1));
  assign timer_hit  = (timer == TMR_W'(TIMEOUT));
  assign busy       = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Outputs decode from the state register, so reset drops them asynchronously.
  always_comb begin
    state_next   = state;
    num_ready    = '0;
    dp_in_valid  = 1'b0;
    dp_in_number = '0;
    dp_mode      = '0;
    rsp_valid    = '0;
    rsp_result   = '0;
    rsp_timeout  = 1'b0;
    case (state)
      IDLE: if (found) state_next = LOAD;
      LOAD: begin
        num_ready = grant;
        if (!g_req)         state_next = IDLE;
        else if (load_last) state_next = ISSUE;
      end
      ISSUE: begin
        dp_in_valid  = 1'b1;
        dp_in_number = buf_mem[idx[BUF_AW-1:0]];
        dp_mode      = mode_reg;
        if (issue_last) state_next = WAIT;
      end
      WAIT: if (dp_out_valid || timer_hit) state_next = RESP;
      RESP: begin
        rsp_valid   = grant;
        rsp_result  = res_reg;
        rsp_timeout = to_flag;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the batch buffer is reset like any register so a reset leaves no stale numbers behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant      <= '0;
      mode_reg   <= '0;
      cnt        <= '0;
      idx        <= '0;
      timer      <= '0;
      res_reg    <= '0;
      to_flag    <= 1'b0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      for (int i = 0; i < BATCH_LEN; i++) buf_mem[i] <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          grant    <= winner;
          mode_reg <= win_mode;
        end
        LOAD: begin
          if (!g_req) begin
            grant      <= '0;
            cnt        <= '0;
            last_grant <= g_idx;
          end else if (accept) begin
            buf_mem[cnt[BUF_AW-1:0]] <= sel_num;
            cnt <= load_last ? '0 : cnt + 1'b1;
          end
        end
        ISSUE: begin
          idx   <= issue_last ? '0 : idx + 1'b1;
          timer <= '0;
        end
        WAIT: begin
          // A result arriving on the last timer cycle wins over the timeout.
          if (dp_out_valid) begin
            res_reg <= dp_out_result;
            to_flag <= 1'b0;
          end else if (timer_hit) begin
            res_reg <= '0;
            to_flag <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          last_grant <= g_idx;
          grant      <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lab06_arbiter.sv
// Directed bench for lab06_arbiter: table of single transactions plus
// hand-written round-robin, abort and mid-burst reset sequences.
module tb_lab06_arbiter;

  localparam int NUM_REQ   = 2;
  localparam int BATCH_LEN = 4;
  localparam int TIMEOUT   = 63;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [1:0]          req_valid = '0;
  logic [3:0]          req_mode = '0;
  logic [1:0]          num_valid = '0;
  logic [7:0]          num_data = '0;
  logic [1:0]          num_ready, grant, rsp_valid;
  logic signed [6:0]   rsp_result;
  logic                rsp_timeout, dp_in_valid, busy;
  logic [3:0]          dp_in_number;
  logic [1:0]          dp_mode;
  logic                dp_out_valid;
  logic signed [6:0]   dp_out_result;

  always #5 clk = ~clk;

  lab06_arbiter #(.NUM_REQ(NUM_REQ), .BATCH_LEN(BATCH_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_mode(req_mode),
    .num_valid(num_valid), .num_data(num_data), .num_ready(num_ready),
    .grant(grant), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_timeout(rsp_timeout),
    .dp_in_valid(dp_in_valid), .dp_in_number(dp_in_number), .dp_mode(dp_mode),
    .dp_out_valid(dp_out_valid), .dp_out_result(dp_out_result), .busy(busy)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Datapath model: records each burst, answers dp_delay cycles after it ends.
  logic [5:0]         cap_q[$];
  int                 run_q[$];
  int                 run_len = 0;
  int                 wait_left = -1;
  int                 dp_delay = 0;
  logic               dp_silent = 1'b0;
  logic signed [6:0]  dp_ret = '0;

  initial begin
    dp_out_valid  = 1'b0;
    dp_out_result = '0;
    forever begin
      @(negedge clk);
      dp_out_valid = 1'b0;
      if (dp_in_valid) begin
        cap_q.push_back({dp_mode, dp_in_number});
        run_len++;
      end else if (run_len != 0) begin
        run_q.push_back(run_len);
        run_len   = 0;
        wait_left = dp_silent ? -1 : dp_delay;
      end
      if (wait_left == 0) begin
        dp_out_valid  = 1'b1;
        dp_out_result = dp_ret;
        wait_left     = -1;
      end else if (wait_left > 0) begin
        wait_left--;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One full transaction for requester r, from raising req_valid to the response pulse.
  task automatic serve(input int r, input logic [1:0] mode, input logic [15:0] nums,
                       input logic [15:0] vpat, input int plen, input int delay,
                       input logic signed [6:0] ret, input logic signed [6:0] exp_res,
                       input logic exp_to, input logic keep);
    int k, p, n, ws, guard;
    logic v, seen;
    logic [5:0] got;
    dp_delay  = (delay < 0) ? 0 : delay;
    dp_silent = (delay < 0);
    dp_ret    = ret;
    req_mode[2*r +: 2] = mode;
    req_valid[r] = 1'b1;
    guard = 0;
    while (grant == '0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("grant_seen", grant != '0, 1);
    check($sformatf("grant_owner_r%0d", r), grant, 1 << r);
    check("num_ready_owner", num_ready, 1 << r);
    k = 0; p = 0; guard = 0;
    while (k < BATCH_LEN && guard < 40) begin
      v = (p < plen) ? vpat[p] : 1'b1;
      p++;
      num_valid[r] = v;
      num_data[4*r +: 4] = nums[4*k +: 4];
      @(negedge clk);
      guard++;
      if (v) k++;
    end
    num_valid[r] = 1'b0;
    check("num_ready_drop", num_ready, 0);
    check("issue_follows_load", dp_in_valid, 1);
    n = 0; ws = -1; seen = 1'b0;
    while (rsp_valid == '0 && n < 200) begin
      if (dp_in_valid) seen = 1'b1;
      else if (seen && ws < 0) ws = n;
      @(negedge clk);
      n++;
    end
    check("rsp_seen", rsp_valid != '0, 1);
    check($sformatf("rsp_index_r%0d", r), rsp_valid, 1 << r);
    check("rsp_result", rsp_result, exp_res);
    check("rsp_timeout", rsp_timeout, exp_to);
    check("wait_to_rsp_cycles", n - ws, (delay < 0) ? TIMEOUT + 1 : delay + 1);
    check("burst_count", run_q.size(), 1);
    if (run_q.size() > 0) check("burst_len", run_q.pop_front(), BATCH_LEN);
    check("burst_words", cap_q.size(), BATCH_LEN);
    for (int i = 0; i < BATCH_LEN && cap_q.size() > 0; i++) begin
      got = cap_q.pop_front();
      check($sformatf("dp_word%0d", i), got, {mode, nums[4*i +: 4]});
    end
    run_q.delete();
    cap_q.delete();
    if (!keep) req_valid[r] = 1'b0;
    @(negedge clk);
    check("rsp_one_cycle", rsp_valid, 0);
    check("grant_cleared", grant, 0);
  endtask

  typedef struct {
    int                r;
    logic [1:0]        mode;
    logic [15:0]       nums;   // nibble k = k-th number
    logic [15:0]       vpat;   // num_valid per LOAD cycle, bit 0 first
    int                plen;   // 0 = back-to-back
    int                delay;  // -1 = datapath never answers
    logic signed [6:0] ret;
    logic signed [6:0] exp_res;
    logic              exp_to;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 2'b01, 16'h1753, 16'h0000,  0, 2,       -7'sd12, -7'sd12, 1'b0};
    vecs[1] = '{1, 2'b10, 16'h280F, 16'h0000,  0, 0,        7'sd63,  7'sd63, 1'b0};
    vecs[2] = '{0, 2'b11, 16'hC96A, 16'h0059,  7, 5,       -7'sd64, -7'sd64, 1'b0};
    vecs[3] = '{1, 2'b00, 16'h4321, 16'h0000,  0, TIMEOUT,  7'sd17,  7'sd17, 1'b0};
    vecs[4] = '{0, 2'b01, 16'hFFFF, 16'h0000,  0, -1,       7'sd25,  7'sd0,  1'b1};
    vecs[5] = '{1, 2'b10, 16'h0123, 16'h0000,  0, 1,       -7'sd1,  -7'sd1,  1'b0};

    // Reset state
    #12;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_num_ready", num_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_dp_in_valid", dp_in_valid, 0);
    check("rst_dp_number", dp_in_number, 0);
    check("rst_dp_mode", dp_mode, 0);
    check("rst_rsp_result", rsp_result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-requester transactions: plain, max result, gaps, timer boundary, timeout, recovery
    for (int i = 0; i < 6; i++)
      serve(vecs[i].r, vecs[i].mode, vecs[i].nums, vecs[i].vpat, vecs[i].plen,
            vecs[i].delay, vecs[i].ret, vecs[i].exp_res, vecs[i].exp_to, 1'b0);

    // Round robin with both held (last owner was requester 1)
    req_valid = 2'b11;
    req_mode  = 4'b1001;
    serve(0, 2'b01, 16'h5A3C, 16'h0, 0, 3, 7'sd5,   7'sd5,   1'b0, 1'b1);
    serve(1, 2'b10, 16'h9876, 16'h0, 0, 0, -7'sd33, -7'sd33, 1'b0, 1'b1);
    serve(0, 2'b01, 16'h1111, 16'h0, 0, 4, 7'sd42,  7'sd42,  1'b0, 1'b0);
    serve(1, 2'b10, 16'h2222, 16'h0, 0, 1, -7'sd7,  -7'sd7,  1'b0, 1'b0);

    // Requester 1 withdraws mid-LOAD while requester 0 is pending
    req_mode[3:2] = 2'b10;
    req_valid[1]  = 1'b1;
    begin
      int guard = 0;
      while (grant == '0 && guard < 10) begin
        @(negedge clk);
        guard++;
      end
    end
    check("abort_grant", grant, 2'b10);
    for (int i = 0; i < 2; i++) begin
      num_valid[1]  = 1'b1;
      num_data[7:4] = 4'(9 + i);
      @(negedge clk);
    end
    num_valid[1] = 1'b0;
    req_valid[1] = 1'b0;
    req_mode[1:0] = 2'b01;
    req_valid[0] = 1'b1;
    @(negedge clk);
    check("abort_grant_clear", grant, 0);
    check("abort_idle", busy, 0);
    check("abort_no_rsp", rsp_valid, 0);
    check("abort_no_dp", dp_in_valid, 0);
    serve(0, 2'b01, 16'h6543, 16'h0, 0, 2, 7'sd9, 7'sd9, 1'b0, 1'b0);

    // Reset mid-ISSUE (last owner was requester 0)
    dp_silent = 1'b1;
    req_mode[3:2] = 2'b11;
    req_valid[1]  = 1'b1;
    begin
      int guard = 0;
      while (grant == '0 && guard < 10) begin
        @(negedge clk);
        guard++;
      end
    end
    check("rst_test_grant", grant, 2'b10);
    for (int i = 0; i < BATCH_LEN; i++) begin
      num_valid[1]  = 1'b1;
      num_data[7:4] = 4'(i + 1);
      @(negedge clk);
    end
    num_valid[1] = 1'b0;
    @(negedge clk);
    check("rst_test_in_issue", dp_in_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_dp_valid", dp_in_valid, 0);
    check("rst_async_grant", grant, 0);
    check("rst_async_busy", busy, 0);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_no_rsp", rsp_valid, 0);
    run_q.delete();
    cap_q.delete();
    rst_n = 1'b1;
    req_valid = 2'b11;
    req_mode  = 4'b1001;
    serve(0, 2'b01, 16'h3210, 16'h0, 0, 0, -7'sd20, -7'sd20, 1'b0, 1'b0);
    serve(1, 2'b10, 16'h7777, 16'h0, 0, 2, 7'sd1,   7'sd1,   1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
